fwd_bypass_unit: RTL

- Parametrised operand-bypass unit for the RV32I pipeline. Generalises the fixed two-source, three-input forwarding muxes.
- Holds its own DEPTH-entry history of in-flight register writes, one entry per post-EX stage. Each entry carries valid, rd, data and a load-pending flag.
- Selects the youngest matching producer for each of NUM_SRC EX-stage operands.
- Merges load data as entries age, and raises a one-cycle load-use stall.

---
 rtl/fwd_bypass_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fwd_bypass_unit.sv
// fwd_bypass_unit: parametrised operand bypass for the RV32I pipeline.
// Keeps a DEPTH-entry history of in-flight register writes (entry 0 = MEM,
// entry DEPTH-1 = oldest/WB) and forwards the youngest matching producer to
// each of NUM_SRC EX operands. A consumer of a load still sitting in entry 0
// gets a one-cycle stall; the load data is merged as the entry ages to 1.
// Optional build macro: FWD_BYPASS_PERF_EN adds saturating perf counters
// (perf_fwd_cnt, perf_stall_cnt).
module fwd_bypass_unit #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  localparam int SW     = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hold,
  input  logic                    ex_valid,
  input  logic                    ex_wr_en,
  input  logic [AW-1:0]           ex_rd,
  input  logic [XLEN-1:0]         ex_result,
  input  logic                    ex_is_load,
  input  logic [XLEN-1:0]         ld_rdata,
  input  logic [NUM_SRC*AW-1:0]   src_rs,
  input  logic [NUM_SRC*XLEN-1:0] src_rf,
  output logic [NUM_SRC*XLEN-1:0] fwd_data,
  output logic [NUM_SRC*SW-1:0]   fwd_sel,
  output logic                    stall
`ifdef FWD_BYPASS_PERF_EN
  ,
  output logic [31:0]             perf_fwd_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);

  // History state, one slot per post-EX stage.
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] wr_q,  wr_d;
  logic [DEPTH-1:0] ld_q,  ld_d;
  logic [AW-1:0]    rd_q   [DEPTH];
  logic [AW-1:0]    rd_d   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [XLEN-1:0]  data_d [DEPTH];

  // Per-channel flags gathered from the channel generate loop.
  logic [NUM_SRC-1:0] ch_stall;
  logic [NUM_SRC-1:0] ch_fwd;

  assign stall = |ch_stall;

  // Operand channels: each picks the youngest matching entry independently.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ch
    logic [AW-1:0]   rs;
    logic [SW-1:0]   sel;
    logic [XLEN-1:0] data;

    assign rs = src_rs[gi*AW +: AW];

    // Scan oldest to youngest so the youngest match overwrites older ones;
    // x0 is hard-wired zero and is never forwarded.
    always_comb begin
      sel  = '0;
      data = src_rf[gi*XLEN +: XLEN];
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (vld_q[k] && wr_q[k] && (rd_q[k] == rs) && (rs != '0)) begin
          sel  = SW'(k + 1);
          data = data_q[k];
        end
      end
    end

    // Load still in entry 0 has no data yet; a younger non-load match has
    // already won the scan above and so masks any older pending load.
    assign ch_stall[gi] = (sel == SW'(1)) && ld_q[0];
    assign ch_fwd[gi]   = (sel != '0);

    assign fwd_sel[gi*SW +: SW]       = sel;
    assign fwd_data[gi*XLEN +: XLEN]  = data;
  end

  // Next history: capture EX into entry 0 (bubble on stall), age the rest,
  // merging load data into the value that leaves entry 0.
  always_comb begin
    vld_d[0]  = ex_valid & ~stall;
    wr_d[0]   = ex_wr_en;
    rd_d[0]   = ex_rd;
    data_d[0] = ex_result;
    ld_d[0]   = ex_is_load & ex_valid & ~stall;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k]  = vld_q[k-1];
      wr_d[k]   = wr_q[k-1];
      rd_d[k]   = rd_q[k-1];
      data_d[k] = ((k == 1) && ld_q[0]) ? ld_rdata : data_q[k-1];
      ld_d[k]   = 1'b0;
    end
  end

  // History registers: cleared on reset, frozen while the pipeline holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      wr_q  <= '0;
      ld_q  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else if (!hold) begin
      vld_q <= vld_d;
      wr_q  <= wr_d;
      ld_q  <= ld_d;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]   <= rd_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

`ifdef FWD_BYPASS_PERF_EN
  logic [31:0] perf_fwd_q;
  logic [31:0] perf_stall_q;

  // Saturating event counters, advanced only on non-hold cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fwd_q   <= '0;
      perf_stall_q <= '0;
    end else if (!hold) begin
      if (stall && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (!stall && (|ch_fwd) && (perf_fwd_q != '1)) begin
        perf_fwd_q <= perf_fwd_q + 32'd1;
      end
    end
  end

  assign perf_fwd_cnt   = perf_fwd_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
